// File: rtl/iram_ctrl_if.sv
// Request bus and SFR bus of the internal-RAM controller.
// The slave modport is the controller's view. The master modport is the view
// of whatever surrounds it: the CPU core on the request side and the SFR block
// on the other side.
interface iram_ctrl_if;
    logic       req;
    logic       ready;
    logic       we;
    logic       is_bit;
    logic       indirect;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic       wbit;
    logic [7:0] rdata;
    logic       rbit;
    logic       rvalid;
    logic       sfr_req;
    logic       sfr_we;
    logic [7:0] sfr_addr;
    logic [7:0] sfr_wdata;
    logic [7:0] sfr_rdata;
    logic       sfr_ack;

    modport slave (
        input  req, we, is_bit, indirect, addr, wdata, wbit, sfr_rdata, sfr_ack,
        output ready, rdata, rbit, rvalid, sfr_req, sfr_we, sfr_addr, sfr_wdata
    );

    modport master (
        output req, we, is_bit, indirect, addr, wdata, wbit, sfr_rdata, sfr_ack,
        input  ready, rdata, rbit, rvalid, sfr_req, sfr_we, sfr_addr, sfr_wdata
    );
endinterface

// File: rtl/iram_ctrl.sv
// Internal RAM controller for an 8051-style core.
// Decodes byte and bit addresses into RAM, SFR or (DEPTH=128) void space.
// Bit writes are done as read-modify-write: RAM updates are local, and SFR
// updates use a read handshake followed by a write handshake.
// After reset the RAM is filled with FILL, one byte per cycle.
// DEPTH must be 128 or 256.
module iram_ctrl #(
    parameter int         DEPTH    = 256,
    parameter logic [7:0] BIT_BASE = 8'h20,
    parameter logic [7:0] FILL     = 8'h00
) (
    input logic        clk,
    input logic        rst,
    iram_ctrl_if.slave bus
);

    localparam int         AW        = (DEPTH == 128) ? 7 : 8;
    localparam logic [7:0] LAST_ADDR = 8'(DEPTH - 1);

    typedef enum logic [2:0] {
        CLEAR,
        IDLE,
        RMW,
        SFR_RD,
        SFR_WR
    } state_t;

    typedef enum logic [1:0] {
        K_RAM,
        K_SFR,
        K_VOID
    } kind_t;

    state_t          state_q, state_d;
    logic [7:0]      clr_cnt_q, clr_cnt_d;
    logic [AW-1:0]   ram_addr_q, ram_addr_d;
    logic [2:0]      bit_sel_q, bit_sel_d;
    logic            we_q, we_d;
    logic            is_bit_q, is_bit_d;
    logic            wbit_q, wbit_d;
    logic [7:0]      sfr_addr_q, sfr_addr_d;
    logic [7:0]      sfr_wdata_q, sfr_wdata_d;
    logic [7:0]      rdata_q, rdata_d;
    logic            rbit_q, rbit_d;
    logic            rvalid_q, rvalid_d;

    logic [7:0]      ram [DEPTH];
    logic            ram_we;
    logic [AW-1:0]   ram_waddr;
    logic [7:0]      ram_wdata;
    logic [7:0]      ram_rd_req;
    logic [7:0]      ram_rd_rmw;

    kind_t           dec_kind;
    logic [7:0]      dec_byte;
    logic [2:0]      dec_bit;

    function automatic logic [7:0] set_bit(input logic [7:0] v, input logic [2:0] sel,
                                           input logic b);
        logic [7:0] r;
        r      = v;
        r[sel] = b;
        return r;
    endfunction

    // Decode the incoming request into a target space, a byte address and a bit index.
    always_comb begin
        dec_kind = K_RAM;
        dec_byte = bus.addr;
        dec_bit  = bus.addr[2:0];
        if (bus.is_bit) begin
            if (!bus.addr[7]) begin
                dec_byte = BIT_BASE + {4'h0, bus.addr[6:3]};
            end else begin
                dec_byte = {bus.addr[7:3], 3'b000};
                dec_kind = K_SFR;
            end
        end else if (bus.addr[7]) begin
            if (!bus.indirect) begin
                dec_kind = K_SFR;
            end else if (DEPTH != 256) begin
                dec_kind = K_VOID;
            end
        end
    end

    assign ram_rd_req = ram[dec_byte[AW-1:0]];
    assign ram_rd_rmw = ram[ram_addr_q];

    // Next-state logic. It covers acceptance, the clear sweep, bit read-modify-write
    // and the SFR handshakes.
    always_comb begin
        state_d     = state_q;
        clr_cnt_d   = clr_cnt_q;
        ram_addr_d  = ram_addr_q;
        bit_sel_d   = bit_sel_q;
        we_d        = we_q;
        is_bit_d    = is_bit_q;
        wbit_d      = wbit_q;
        sfr_addr_d  = sfr_addr_q;
        sfr_wdata_d = sfr_wdata_q;
        rdata_d     = rdata_q;
        rbit_d      = rbit_q;
        rvalid_d    = 1'b0;
        ram_we      = 1'b0;
        ram_waddr   = ram_addr_q;
        ram_wdata   = 8'h00;

        unique case (state_q)
            CLEAR: begin
                ram_we    = 1'b1;
                ram_waddr = clr_cnt_q[AW-1:0];
                ram_wdata = FILL;
                if (clr_cnt_q == LAST_ADDR) begin
                    state_d = IDLE;
                end else begin
                    clr_cnt_d = clr_cnt_q + 8'd1;
                end
            end
            IDLE: begin
                if (bus.req) begin
                    ram_addr_d = dec_byte[AW-1:0];
                    bit_sel_d  = dec_bit;
                    we_d       = bus.we;
                    is_bit_d   = bus.is_bit;
                    wbit_d     = bus.wbit;
                    unique case (dec_kind)
                        K_RAM: begin
                            if (bus.we) begin
                                if (bus.is_bit) begin
                                    state_d = RMW;
                                end else begin
                                    ram_we    = 1'b1;
                                    ram_waddr = dec_byte[AW-1:0];
                                    ram_wdata = bus.wdata;
                                end
                            end else begin
                                rdata_d  = ram_rd_req;
                                rbit_d   = bus.is_bit ? ram_rd_req[dec_bit] : 1'b0;
                                rvalid_d = 1'b1;
                            end
                        end
                        K_VOID: begin
                            if (!bus.we) begin
                                rdata_d  = 8'h00;
                                rbit_d   = 1'b0;
                                rvalid_d = 1'b1;
                            end
                        end
                        default: begin
                            sfr_addr_d = dec_byte;
                            if (bus.we && !bus.is_bit) begin
                                sfr_wdata_d = bus.wdata;
                                state_d     = SFR_WR;
                            end else begin
                                state_d = SFR_RD;
                            end
                        end
                    endcase
                end
            end
            RMW: begin
                ram_we    = 1'b1;
                ram_waddr = ram_addr_q;
                ram_wdata = set_bit(ram_rd_rmw, bit_sel_q, wbit_q);
                state_d   = IDLE;
            end
            SFR_RD: begin
                if (bus.sfr_ack) begin
                    if (we_q) begin
                        sfr_wdata_d = set_bit(bus.sfr_rdata, bit_sel_q, wbit_q);
                        state_d     = SFR_WR;
                    end else begin
                        rdata_d  = bus.sfr_rdata;
                        rbit_d   = is_bit_q ? bus.sfr_rdata[bit_sel_q] : 1'b0;
                        rvalid_d = 1'b1;
                        state_d  = IDLE;
                    end
                end
            end
            SFR_WR: begin
                if (bus.sfr_ack) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = CLEAR;
            end
        endcase
    end

    // Register the controller state. Reset aborts any SFR handshake and restarts the clear sweep.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= CLEAR;
            clr_cnt_q   <= 8'h00;
            ram_addr_q  <= '0;
            bit_sel_q   <= 3'd0;
            we_q        <= 1'b0;
            is_bit_q    <= 1'b0;
            wbit_q      <= 1'b0;
            sfr_addr_q  <= 8'h00;
            sfr_wdata_q <= 8'h00;
            rdata_q     <= 8'h00;
            rbit_q      <= 1'b0;
            rvalid_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            clr_cnt_q   <= clr_cnt_d;
            ram_addr_q  <= ram_addr_d;
            bit_sel_q   <= bit_sel_d;
            we_q        <= we_d;
            is_bit_q    <= is_bit_d;
            wbit_q      <= wbit_d;
            sfr_addr_q  <= sfr_addr_d;
            sfr_wdata_q <= sfr_wdata_d;
            rdata_q     <= rdata_d;
            rbit_q      <= rbit_d;
            rvalid_q    <= rvalid_d;
        end
    end

    // Single write port of the RAM array. The array has no reset; the clear sweep initialises it.
    always_ff @(posedge clk) begin
        if (ram_we && !rst) begin
            ram[ram_waddr] <= ram_wdata;
        end
    end

    // Outputs are forced idle while rst is high, so nothing leaks out during the reset cycle.
    assign bus.ready     = !rst && (state_q == IDLE);
    assign bus.rvalid    = !rst && rvalid_q;
    assign bus.rdata     = rst ? 8'h00 : rdata_q;
    assign bus.rbit      = !rst && rbit_q;
    assign bus.sfr_req   = !rst && ((state_q == SFR_RD) || (state_q == SFR_WR));
    assign bus.sfr_we    = !rst && (state_q == SFR_WR);
    assign bus.sfr_addr  = rst ? 8'h00 : sfr_addr_q;
    assign bus.sfr_wdata = rst ? 8'h00 : sfr_wdata_q;

endmodule

// File: tb/tb_iram_ctrl.sv
// Directed bench for iram_ctrl.
// u256 is DEPTH=256 with FILL=A5. u128 is DEPTH=128 with FILL=00.
// Both instances share clk and rst.
module tb_iram_ctrl;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    iram_ctrl_if bus256 ();
    iram_ctrl_if bus128 ();

    iram_ctrl #(.DEPTH(256), .BIT_BASE(8'h20), .FILL(8'hA5)) u256 (
        .clk (clk),
        .rst (rst),
        .bus (bus256.slave)
    );

    iram_ctrl #(.DEPTH(128), .BIT_BASE(8'h20), .FILL(8'h00)) u128 (
        .clk (clk),
        .rst (rst),
        .bus (bus128.slave)
    );

    // Free-running 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case something never returns
    initial begin
        #200000;
        $display("[TB] FAIL watchdog got=timeout exp=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Present one request for a single accepting edge, then withdraw it
    task automatic applyStimulus(input bit sel128, input bit we, input bit isb, input bit ind,
                                 input logic [7:0] a, input logic [7:0] wd, input bit wb);
        if (sel128) begin
            checkOutput("ready_before_req128", {31'd0, bus128.ready}, 32'd1);
            bus128.we = we; bus128.is_bit = isb; bus128.indirect = ind;
            bus128.addr = a; bus128.wdata = wd; bus128.wbit = wb; bus128.req = 1'b1;
        end else begin
            checkOutput("ready_before_req", {31'd0, bus256.ready}, 32'd1);
            bus256.we = we; bus256.is_bit = isb; bus256.indirect = ind;
            bus256.addr = a; bus256.wdata = wd; bus256.wbit = wb; bus256.req = 1'b1;
        end
        tick();
        bus256.req = 1'b0;
        bus128.req = 1'b0;
    endtask

    task automatic waitClear(output int n256, output int n128, output bit saw_req);
        n256    = 0;
        n128    = 0;
        saw_req = 1'b0;
        while (!bus256.ready && n256 < 400) begin
            tick();
            n256++;
            if (bus256.sfr_req) saw_req = 1'b1;
            if (n256 == 4) bus256.sfr_ack = 1'b0;
            if (bus128.ready && n128 == 0) n128 = n256;
        end
    endtask

    initial begin
        int  n256;
        int  n128;
        bit  saw_req;

        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        bus256.req = 0; bus256.we = 0; bus256.is_bit = 0; bus256.indirect = 0;
        bus256.addr = 0; bus256.wdata = 0; bus256.wbit = 0;
        bus256.sfr_rdata = 0; bus256.sfr_ack = 0;
        bus128.req = 0; bus128.we = 0; bus128.is_bit = 0; bus128.indirect = 0;
        bus128.addr = 0; bus128.wdata = 0; bus128.wbit = 0;
        bus128.sfr_rdata = 0; bus128.sfr_ack = 0;

        tick(); tick(); tick();
        checkOutput("rst_outputs", {bus256.ready, bus256.rvalid, bus256.rbit, bus256.sfr_req,
                                    bus256.sfr_we, bus256.rdata, bus256.sfr_addr, bus256.sfr_wdata},
                    32'd0);
        rst = 1'b0;

        // Clear sweep: 256 and 128 cycles respectively
        waitClear(n256, n128, saw_req);
        checkOutput("clear_len_256", n256, 256);
        checkOutput("clear_len_128", n128, 128);

        // Filled contents visible at top of lower half and top of upper half
        applyStimulus(0, 0, 0, 0, 8'h7F, 8'h00, 0);
        checkOutput("rd_7f", {bus256.rvalid, bus256.rbit, bus256.rdata}, {22'd0, 1'b1, 1'b0, 8'hA5});
        tick();
        checkOutput("rvalid_one_cycle", {31'd0, bus256.rvalid}, 32'd0);
        applyStimulus(0, 0, 0, 1, 8'hFF, 8'h00, 0);
        checkOutput("rd_ff_ind", {bus256.rvalid, bus256.rdata}, {23'd0, 1'b1, 8'hA5});
        checkOutput("rd_ff_no_sfr", {31'd0, bus256.sfr_req}, 32'd0);

        // Bit write through RMW
        applyStimulus(0, 1, 0, 0, 8'h21, 8'h00, 0);
        checkOutput("byte_wr_no_rvalid", {31'd0, bus256.rvalid}, 32'd0);
        applyStimulus(0, 1, 1, 0, 8'h0B, 8'h00, 1);
        checkOutput("rmw_ready_low", {31'd0, bus256.ready}, 32'd0);
        tick();
        checkOutput("rmw_ready_back", {31'd0, bus256.ready}, 32'd1);
        applyStimulus(0, 0, 0, 0, 8'h21, 8'h00, 0);
        checkOutput("rd_21", {bus256.rvalid, bus256.rdata}, {23'd0, 1'b1, 8'h08});
        applyStimulus(0, 0, 1, 0, 8'h0B, 8'h00, 0);
        checkOutput("bitrd_0b", {bus256.rvalid, bus256.rbit, bus256.rdata}, {22'd0, 1'b1, 1'b1, 8'h08});
        applyStimulus(0, 0, 1, 0, 8'h0C, 8'h00, 0);
        checkOutput("bitrd_0c", {bus256.rvalid, bus256.rbit}, {30'd0, 1'b1, 1'b0});

        // Back-to-back write then read of the same byte, and an upper-half write
        applyStimulus(0, 1, 0, 0, 8'h30, 8'h5A, 0);
        applyStimulus(0, 0, 0, 0, 8'h30, 8'h00, 0);
        checkOutput("b2b_30", {bus256.rvalid, bus256.rdata}, {23'd0, 1'b1, 8'h5A});
        applyStimulus(0, 1, 0, 1, 8'h90, 8'h77, 0);
        applyStimulus(0, 0, 0, 1, 8'h90, 8'h00, 0);
        checkOutput("ind_90", {bus256.rvalid, bus256.rdata}, {23'd0, 1'b1, 8'h77});

        // SFR byte write held for three cycles; input changes while busy are ignored
        applyStimulus(0, 1, 0, 0, 8'hE0, 8'h3C, 0);
        for (int i = 0; i < 3; i++) begin
            checkOutput($sformatf("sfr_wr_hold%0d", i),
                        {bus256.sfr_req, bus256.sfr_we, bus256.sfr_addr, bus256.sfr_wdata},
                        {14'd0, 1'b1, 1'b1, 8'hE0, 8'h3C});
            if (i == 1) begin
                bus256.req = 1'b1; bus256.addr = 8'h55; bus256.wdata = 8'hFF;
            end
            if (i == 2) begin
                bus256.req = 1'b0;
                bus256.sfr_ack = 1'b1;
            end
            tick();
        end
        bus256.sfr_ack = 1'b0;
        checkOutput("sfr_wr_done", {bus256.sfr_req, bus256.ready}, {30'd0, 1'b0, 1'b1});

        // SFR bit write: read handshake at D0, then write of FF with bit 5 cleared
        applyStimulus(0, 1, 1, 0, 8'hD5, 8'h00, 0);
        checkOutput("sfr_bw_rd", {bus256.sfr_req, bus256.sfr_we, bus256.sfr_addr},
                    {22'd0, 1'b1, 1'b0, 8'hD0});
        bus256.sfr_rdata = 8'hFF;
        bus256.sfr_ack   = 1'b1;
        tick();
        checkOutput("sfr_bw_wr", {bus256.sfr_req, bus256.sfr_we, bus256.sfr_addr, bus256.sfr_wdata},
                    {14'd0, 1'b1, 1'b1, 8'hD0, 8'hDF});
        checkOutput("sfr_bw_no_rvalid", {31'd0, bus256.rvalid}, 32'd0);
        tick();
        bus256.sfr_ack = 1'b0;
        checkOutput("sfr_bw_done", {bus256.sfr_req, bus256.rvalid, bus256.ready},
                    {29'd0, 1'b0, 1'b0, 1'b1});

        // SFR bit read
        applyStimulus(0, 0, 1, 0, 8'hD5, 8'h00, 0);
        bus256.sfr_rdata = 8'h20;
        bus256.sfr_ack   = 1'b1;
        tick();
        bus256.sfr_ack = 1'b0;
        checkOutput("sfr_bitrd", {bus256.rvalid, bus256.rbit, bus256.rdata}, {22'd0, 1'b1, 1'b1, 8'h20});

        // DEPTH=128: indirect access above 0x7F is void space
        applyStimulus(1, 1, 0, 1, 8'h90, 8'h33, 0);
        checkOutput("d128_wr_no_sfr", {bus128.sfr_req, bus128.ready}, {30'd0, 1'b0, 1'b1});
        applyStimulus(1, 0, 0, 1, 8'h90, 8'h00, 0);
        checkOutput("d128_rd_90", {bus128.rvalid, bus128.sfr_req, bus128.rdata},
                    {22'd0, 1'b1, 1'b0, 8'h00});

        // Reset in the middle of an SFR read
        applyStimulus(0, 0, 0, 0, 8'h90, 8'h00, 0);
        checkOutput("pre_rst_sfr_req", {31'd0, bus256.sfr_req}, 32'd1);
        rst = 1'b1;
        tick();
        checkOutput("rst_mid_sfr", {bus256.sfr_req, bus256.ready, bus256.sfr_addr},
                    {22'd0, 1'b0, 1'b0, 8'h00});
        rst = 1'b0;
        bus256.sfr_ack = 1'b1;
        waitClear(n256, n128, saw_req);
        checkOutput("clear_len_again", n256, 256);
        checkOutput("ack_in_clear_ignored", {31'd0, saw_req}, 32'd0);
        applyStimulus(0, 0, 0, 0, 8'h21, 8'h00, 0);
        checkOutput("refilled_21", {bus256.rvalid, bus256.rdata}, {23'd0, 1'b1, 8'hA5});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
